mem_responder: RTL and testbench

//  Memory-side responder for the MCU bus: 2**AW x DW RAM that serves the MCU's rd/wr/dout_en requests.

---
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder.sv | 101 ++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus bundle between the MCU/host side and the memory responder.
// Preload handshake: a word transfers on every rising edge where ld_valid and
// ld_ready are both high; the host holds ld_data/ld_last stable while
// ld_valid is high and not yet accepted, and ld_ready never depends on
// ld_valid.
interface mem_responder_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic          sig_rd;
  logic          sig_wr;
  logic          sig_dout_en;
  logic [DW-1:0] memory_ou;
  logic [DW-1:0] memory_in;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output mem_addr, sig_rd, sig_wr, sig_dout_en, memory_ou,
    output ld_valid, ld_data, ld_last,
    input  memory_in, ld_ready
  );

  modport slave (
    input  mem_addr, sig_rd, sig_wr, sig_dout_en, memory_ou,
    input  ld_valid, ld_data, ld_last,
    output memory_in, ld_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the MCU bus: a 2**AW x DW RAM serving MCU
// reads/writes, with a host preload port. A LOAD->RUN FSM keeps the MCU in
// reset (mcu_hold) until the program image has been loaded.
module mem_responder #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int RD_LAT  = 1,
  parameter bit BOOT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  output logic                 mcu_hold,
  output logic                 bus_err,
  output logic [AW-1:0]        load_cnt,
  output logic                 fsm_state   // debug: 0 = LOAD, 1 = RUN
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          ld_ready_c;
  logic          load_accept;
  logic          in_run;
  logic          mcu_wr_ok;
  logic          mcu_rd_ok;
  logic          proto_err;
  logic [DW-1:0] ram [DEPTH];

  assign in_run    = (state_q == S_RUN);
  assign mcu_wr_ok = in_run & bus.sig_wr & bus.sig_dout_en & ~bus.sig_rd;
  assign mcu_rd_ok = in_run & bus.sig_rd & ~bus.sig_wr;
  // rd+wr collision, write without data drive, or data drive during a read
  assign proto_err = in_run & ((bus.sig_rd & bus.sig_wr) |
                               (bus.sig_wr & ~bus.sig_dout_en) |
                               (bus.sig_dout_en & bus.sig_rd));

  assign bus.ld_ready = ld_ready_c;
  assign fsm_state    = state_q;

  // State register; reset picks the boot mode
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT_EN ? S_LOAD : S_RUN;
    else       state_q <= state_d;
  end

  // Next state and per-state outputs; a last-flagged or top-of-RAM word ends LOAD
  always_comb begin
    state_d     = state_q;
    ld_ready_c  = 1'b0;
    mcu_hold    = 1'b0;
    load_accept = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready_c = 1'b1;
        mcu_hold   = 1'b1;
        if (bus.ld_valid) begin
          load_accept = 1'b1;
          if (bus.ld_last || (&load_cnt)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  // Preload pointer; wraps naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset)            load_cnt <= '0;
    else if (load_accept) load_cnt <= load_cnt + 1'b1;
  end

  // Sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (reset)          bus_err <= 1'b0;
    else if (proto_err) bus_err <= 1'b1;
  end

  // RAM write port, shared by preload (LOAD) and MCU writes (RUN); never cleared
  always_ff @(posedge clk) begin
    if (load_accept)    ram[load_cnt]     <= bus.ld_data;
    else if (mcu_wr_ok) ram[bus.mem_addr] <= bus.memory_ou;
  end

  generate
    if (RD_LAT == 1) begin : g_rd_reg
      logic [DW-1:0] rdata_q;
      // Registered read data, held until the next valid read
      always_ff @(posedge clk) begin
        if (reset)          rdata_q <= '0;
        else if (mcu_rd_ok) rdata_q <= ram[bus.mem_addr];
      end
      assign bus.memory_in = rdata_q;
    end else begin : g_rd_comb
      assign bus.memory_in = mcu_rd_ok ? ram[bus.mem_addr] : '0;
    end
  endgenerate
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (AW=5, DW=8, RD_LAT=1, BOOT_EN=1).
// A behavioural model tracks RAM contents, boot phase, preload count, error
// flag and last-read data; a compare process checks the DUT every cycle and
// the directed sequence pins key points with literal values.
module tb_mem_responder;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 32;

  logic          clk;
  logic          reset;
  logic          mcu_hold;
  logic          bus_err;
  logic [AW-1:0] load_cnt;
  logic          fsm_state;

  mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  mem_responder #(.AW(AW), .DW(DW), .RD_LAT(1), .BOOT_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mcu_hold  (mcu_hold),
    .bus_err   (bus_err),
    .load_cnt  (load_cnt),
    .fsm_state (fsm_state)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_ram   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_booting;
  int            m_count;
  bit            m_err;
  logic [DW-1:0] m_rdata;
  bit            m_rknown;
  bit            model_live = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_booting  = 1'b1;
      m_count    = 0;
      m_err      = 1'b0;
      m_rdata    = '0;
      m_rknown   = 1'b1;
      model_live = 1'b1;
    end else if (model_live) begin
      if (m_booting) begin
        if (bus.ld_valid) begin
          m_ram[m_count]   = bus.ld_data;
          m_known[m_count] = 1'b1;
          if (bus.ld_last || m_count == DEPTH - 1) m_booting = 1'b0;
          m_count = (m_count + 1) % DEPTH;
        end
      end else begin
        if ((bus.sig_rd && bus.sig_wr) || (bus.sig_wr && !bus.sig_dout_en) ||
            (bus.sig_dout_en && bus.sig_rd))
          m_err = 1'b1;
        if (bus.sig_wr && bus.sig_dout_en && !bus.sig_rd) begin
          m_ram[bus.mem_addr]   = bus.memory_ou;
          m_known[bus.mem_addr] = 1'b1;
        end
        if (bus.sig_rd && !bus.sig_wr) begin
          m_rdata  = m_ram[bus.mem_addr];
          m_rknown = m_known[bus.mem_addr];
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled just after the edge
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      chk("cyc_mcu_hold", 32'(mcu_hold), 32'(m_booting));
      chk("cyc_ld_ready", 32'(bus.ld_ready), 32'(m_booting));
      chk("cyc_load_cnt", 32'(load_cnt), 32'(m_count));
      chk("cyc_bus_err", 32'(bus_err), 32'(m_err));
      if (m_rknown) chk("cyc_memory_in", 32'(bus.memory_in), 32'(m_rdata));
    end
  end

  // Pop the next literal read expectation and check memory_in against it
  task automatic chk_read(input string name);
    logic [DW-1:0] e;
    e = exp_q.pop_front();
    chk(name, 32'(bus.memory_in), 32'(e));
  endtask

  // ---------------- drivers (inputs change on the falling edge) ----------------
  task automatic idle_inputs();
    bus.mem_addr    = '0;
    bus.sig_rd      = 1'b0;
    bus.sig_wr      = 1'b0;
    bus.sig_dout_en = 1'b0;
    bus.memory_ou   = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_data     = '0;
    bus.ld_last     = 1'b0;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mcu_cycle(input logic [AW-1:0] a, input logic rd, input logic wr,
                           input logic de, input logic [DW-1:0] d);
    bus.mem_addr    = a;
    bus.sig_rd      = rd;
    bus.sig_wr      = wr;
    bus.sig_dout_en = de;
    bus.memory_ou   = d;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    chk("rst_mcu_hold", 32'(mcu_hold), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_load_cnt", 32'(load_cnt), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_memory_in", 32'(bus.memory_in), 32'd0);
    @(negedge clk);

    // 2: three-word preload ending with ld_last
    load_word(8'hA1, 1'b0);
    load_word(8'hB2, 1'b0);
    load_word(8'hC3, 1'b1);
    chk("pl3_load_cnt", 32'(load_cnt), 32'd3);
    chk("pl3_mcu_hold", 32'(mcu_hold), 32'd0);
    chk("pl3_ld_ready", 32'(bus.ld_ready), 32'd0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    mcu_cycle(5'd0, 1'b1, 1'b0, 1'b0, 8'h00); chk_read("pl3_ram0");
    mcu_cycle(5'd1, 1'b1, 1'b0, 1'b0, 8'h00); chk_read("pl3_ram1");
    mcu_cycle(5'd2, 1'b1, 1'b0, 1'b0, 8'h00); chk_read("pl3_ram2");

    // 3: write then read-after-write on the next cycle
    mcu_cycle(5'd5, 1'b0, 1'b1, 1'b1, 8'h3C);
    mcu_cycle(5'd5, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h3C); chk_read("raw_addr5");
    chk("raw_bus_err", 32'(bus_err), 32'd0);

    // 4: rd & wr together -> no write, memory_in held, sticky error
    mcu_cycle(5'd2, 1'b1, 1'b1, 1'b1, 8'hFF);
    exp_q.push_back(8'h3C); chk_read("rdwr_hold");
    chk("rdwr_bus_err", 32'(bus_err), 32'd1);
    repeat (3) @(negedge clk);
    chk("rdwr_sticky", 32'(bus_err), 32'd1);
    mcu_cycle(5'd2, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'hC3); chk_read("rdwr_ram2");

    // 6: fresh run; write without dout_en, ld_valid while running
    do_reset();
    chk("rst2_bus_err", 32'(bus_err), 32'd0);
    load_word(8'hA1, 1'b1);
    mcu_cycle(5'd7, 1'b0, 1'b1, 1'b1, 8'h77);
    chk("wr7_bus_err", 32'(bus_err), 32'd0);
    mcu_cycle(5'd7, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("nodrv_bus_err", 32'(bus_err), 32'd1);
    mcu_cycle(5'd7, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h77); chk_read("nodrv_ram7");
    load_word(8'h55, 1'b0);
    chk("runld_load_cnt", 32'(load_cnt), 32'd1);
    mcu_cycle(5'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'hB2); chk_read("runld_ram1");

    // 5a: reset after ten preload words; earlier words survive
    do_reset();
    for (int i = 0; i < 10; i++) load_word(8'(8'h10 + i), 1'b0);
    chk("mid_load_cnt", 32'(load_cnt), 32'd10);
    do_reset();
    chk("mid_rst_load_cnt", 32'(load_cnt), 32'd0);
    chk("mid_rst_mcu_hold", 32'(mcu_hold), 32'd1);
    load_word(8'hEE, 1'b1);
    mcu_cycle(5'd5, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h15); chk_read("mid_ram5");
    mcu_cycle(5'd9, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h19); chk_read("mid_ram9");

    // 5b: full 32-word preload without ld_last wraps the pointer
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) load_word(8'(8'h40 + i), 1'b0);
    chk("full31_mcu_hold", 32'(mcu_hold), 32'd1);
    chk("full31_load_cnt", 32'(load_cnt), 32'd31);
    load_word(8'h5F, 1'b0);
    chk("full32_mcu_hold", 32'(mcu_hold), 32'd0);
    chk("full32_load_cnt", 32'(load_cnt), 32'd0);
    mcu_cycle(5'd31, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h5F); chk_read("full_ram31");
    mcu_cycle(5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h40); chk_read("full_ram0");

    // bus contention: read still performed, error set
    mcu_cycle(5'd3, 1'b1, 1'b0, 1'b1, 8'h00);
    exp_q.push_back(8'h43); chk_read("cont_ram3");
    chk("cont_bus_err", 32'(bus_err), 32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
